// File: rtl/reg_dump_uart.sv
// Register-file dump engine: walks r0..r31 through the core's read port and prints each value
// as eight uppercase hex digits plus CR LF on a UART 8N1 line.
module reg_dump_uart #(
    parameter int unsigned CLKS_PER_BIT = 434
) (
    input  logic        i_clock,
    input  logic        i_reset,
    input  logic        i_start,
    input  logic [31:0] i_regout,
    output logic [4:0]  o_addrout,
    output logic        o_tx,
    output logic        o_busy,
    output logic        o_done
);

    localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {StIdle, StSettle, StCapture, StSend} state_t;

    state_t           r_state;
    logic [4:0]       r_addr;
    logic             r_tx;
    logic             r_busy;
    logic             r_done;
    logic [31:0]      r_hold;
    logic [3:0]       r_char_idx;
    logic [3:0]       r_bit_idx;
    logic [CNT_W-1:0] r_clk_cnt;

    logic [3:0]       w_nibble;
    logic [7:0]       w_char;
    logic [15:0]      w_frame;
    logic [3:0]       w_next_idx;
    logic             w_next_bit;

    // Char 0 is the most significant nibble of the held value.
    always_comb begin
        w_nibble = r_hold[{~r_char_idx[2:0], 2'b00} +: 4];
        if (r_char_idx == 4'd8) begin
            w_char = 8'h0D;
        end else if (r_char_idx == 4'd9) begin
            w_char = 8'h0A;
        end else if (w_nibble < 4'd10) begin
            w_char = 8'h30 + {4'h0, w_nibble};
        end else begin
            w_char = 8'h37 + {4'h0, w_nibble};
        end
        // Frame bit order: start(0), data LSB first, stop(1); upper padding idles high.
        w_frame    = {6'h3F, 1'b1, w_char, 1'b0};
        w_next_idx = r_bit_idx + 4'd1;
        w_next_bit = w_frame[w_next_idx];
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_state    <= StIdle;
            r_addr     <= 5'd0;
            r_tx       <= 1'b1;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_hold     <= 32'd0;
            r_char_idx <= 4'd0;
            r_bit_idx  <= 4'd0;
            r_clk_cnt  <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                StIdle: begin
                    if (i_start) begin
                        r_addr  <= 5'd0;
                        r_busy  <= 1'b1;
                        r_state <= StSettle;
                    end
                end
                StSettle: begin
                    r_state <= StCapture;
                end
                StCapture: begin
                    r_hold     <= i_regout;
                    r_char_idx <= 4'd0;
                    r_bit_idx  <= 4'd0;
                    r_clk_cnt  <= '0;
                    r_tx       <= 1'b0;
                    r_state    <= StSend;
                end
                StSend: begin
                    if (r_clk_cnt != CNT_MAX) begin
                        r_clk_cnt <= r_clk_cnt + 1'b1;
                    end else begin
                        r_clk_cnt <= '0;
                        if (r_bit_idx != 4'd9) begin
                            r_bit_idx <= w_next_idx;
                            r_tx      <= w_next_bit;
                        end else if (r_char_idx != 4'd9) begin
                            r_char_idx <= r_char_idx + 4'd1;
                            r_bit_idx  <= 4'd0;
                            r_tx       <= 1'b0;
                        end else if (r_addr != 5'd31) begin
                            // Line finished: move to the next register, tx rests at stop level.
                            r_addr  <= r_addr + 5'd1;
                            r_state <= StSettle;
                        end else begin
                            r_done  <= 1'b1;
                            r_busy  <= 1'b0;
                            r_state <= StIdle;
                        end
                    end
                end
                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

    assign o_addrout = r_addr;
    assign o_tx      = r_tx;
    assign o_busy    = r_busy;
    assign o_done    = r_done;

endmodule
